// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the fetch stage and its consumers.
// Holds the datapath and field widths, the major opcode constants, the
// FIFO entry layout, and a helper that extracts the 4-bit ALU Funct field.
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int OPCODE_W = 7;
    localparam int FUNCT_W  = 4;

    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;

    // One buffered fetch result: the address it was fetched from and the word.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // ALU Funct field as consumed by ALUControl: {funct7[5], funct3}.
    function automatic logic [FUNCT_W-1:0] alu_funct(input logic [XLEN-1:0] instr);
        return {instr[30], instr[14:12]};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry {pc, instr} buffer between instruction memory and decode.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   push        - write push_entry this cycle
//   pop         - retire the head entry this cycle
//   flush       - discard all entries (wins over push and pop)
//   push_entry  - entry to write
//   head        - oldest entry (registered)
//   count       - number of valid entries, 0..2
// Push and pop in the same cycle are legal at any count, including when full.
module fetch_fifo
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t head_r;
    fetch_entry_t tail_r;
    logic [1:0]   count_r;

    // Entry storage and occupancy update; the head is always slot head_r.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else if (flush) begin
            count_r <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    case (count_r)
                        2'd0: begin
                            head_r  <= push_entry;
                            count_r <= 2'd1;
                        end
                        2'd1: begin
                            tail_r  <= push_entry;
                            count_r <= 2'd2;
                        end
                        default: ;
                    endcase
                end
                2'b01: begin
                    if (count_r != 2'd0) begin
                        head_r  <= tail_r;
                        count_r <= count_r - 2'd1;
                    end
                end
                2'b11: begin
                    case (count_r)
                        2'd0: begin
                            head_r  <= push_entry;
                            count_r <= 2'd1;
                        end
                        2'd1: head_r <= push_entry;
                        default: begin
                            // Full: shift the tail forward and refill it.
                            head_r <= tail_r;
                            tail_r <= push_entry;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign head  = head_r;
    assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Keeps the PC, issues one word read per
// cycle while buffer space is guaranteed, buffers responses in fetch_fifo and
// hands them to decode with a valid/ready handshake. A taken branch redirects
// the PC and flushes all instructions fetched down the old path.
// Ports:
//   clk, rst_n                 - clock and synchronous active-low reset
//   imem_req, imem_addr        - read request and word address to instruction memory
//   imem_rdata                 - read data, valid one cycle after an accepted request
//   branch_taken, branch_target- redirect pulse and new PC (bits [1:0] ignored)
//   out_valid, out_ready       - decode handshake
//   out_instr, out_pc          - head instruction and its address
//   out_opcode, out_funct      - pre-decoded opcode and ALU Funct field
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic [XLEN-1:0]     imem_rdata,
    input  logic                branch_taken,
    input  logic [XLEN-1:0]     branch_target,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_instr,
    output logic [XLEN-1:0]     out_pc,
    output logic [OPCODE_W-1:0] out_opcode,
    output logic [FUNCT_W-1:0]  out_funct
);

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] req_pc_r;
    logic            inflight_r;
    logic            drop_r;

    logic [1:0]      count_s;
    fetch_entry_t    head_s;
    fetch_entry_t    push_entry_s;
    logic            pop_s;
    logic            push_s;
    logic            issue_s;
    logic [2:0]      occupancy_s;

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (branch_taken),
        .push_entry (push_entry_s),
        .head       (head_s),
        .count      (count_s)
    );

    // Handshake, issue and push decisions. Issue only when the buffered plus
    // in-flight instructions, after this cycle's pop, leave room for one more,
    // so a response always finds a free slot and memory never has to stall.
    always_comb begin
        out_valid    = 1'b0;
        pop_s        = 1'b0;
        issue_s      = 1'b0;
        push_s       = 1'b0;
        occupancy_s  = 3'd0;
        push_entry_s = '{pc: req_pc_r, instr: imem_rdata};
        if (rst_n) begin
            out_valid   = (count_s != 2'd0);
            pop_s       = out_valid && out_ready;
            occupancy_s = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
            issue_s     = !branch_taken && (occupancy_s < 3'(DEPTH));
            // A response arriving in a redirect cycle belongs to the old path.
            push_s      = inflight_r && !drop_r && !branch_taken;
        end else begin
            out_valid = 1'b0;
        end
    end

    // Decode-facing fields come straight from the FIFO head register.
    always_comb begin
        out_instr  = 32'h0000_0000;
        out_pc     = 32'h0000_0000;
        if (rst_n) begin
            out_instr = head_s.instr;
            out_pc    = head_s.pc;
        end else begin
            out_instr = 32'h0000_0000;
        end
        out_opcode = out_instr[OPCODE_W-1:0];
        out_funct  = alu_funct(out_instr);
    end

    assign imem_req  = issue_s;
    assign imem_addr = pc_r;

    // PC, outstanding-request tracking and redirect drop flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r       <= RESET_PC;
            req_pc_r   <= 32'h0000_0000;
            inflight_r <= 1'b0;
            drop_r     <= 1'b0;
        end else if (branch_taken) begin
            pc_r       <= branch_target & 32'hFFFF_FFFC;
            drop_r     <= inflight_r;
            inflight_r <= 1'b0;
        end else begin
            drop_r <= 1'b0;
            if (issue_s) begin
                pc_r       <= pc_r + 32'd4;
                req_pc_r   <= pc_r;
                inflight_r <= 1'b1;
            end else begin
                inflight_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit. A small
// never-stalling instruction memory returns mem[a] = a ^ 32'hA5A5_0000, except
// two hand-placed R-type words at 0x40 (sub) and 0x44 (and).
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [3:0]  out_funct;

    int errors = 0;
    int checks = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_opcode    (out_opcode),
        .out_funct     (out_funct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h4000_0033;
        else if (a == 32'h0000_0044) return 32'h0000_7033;
        else return a ^ 32'hA5A5_0000;
    endfunction

    // Memory answers exactly one cycle after a request; garbage otherwise.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
        else          imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, "_pc"}, out_pc, pc);
        check_eq({tag, "_instr"}, out_instr, mem_word(pc));
    endtask

    initial begin
        rst_n         = 1'b0;
        out_ready     = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'h0000_0000;
        imem_rdata    = 32'h0000_0000;
        repeat (3) step();
        #1;
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_instr", out_instr, 32'd0);
        check_eq("rst_pc", out_pc, 32'd0);

        // Stream from reset with decode always ready.
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            check_eq("str_req", {31'd0, imem_req}, 32'd1);
            check_eq("str_addr", imem_addr, 32'(4 * k));
            if (k < 2) begin
                check_eq("str_valid_early", {31'd0, out_valid}, 32'd0);
            end else begin
                check_head("str", 32'(4 * (k - 2)));
            end
            if (k == 18) begin
                check_eq("sub_opcode", {25'd0, out_opcode}, {25'd0, OP_RTYPE});
                check_eq("sub_funct", {28'd0, out_funct}, 32'h8);
            end
            if (k == 19) begin
                check_eq("and_opcode", {25'd0, out_opcode}, 32'h33);
                check_eq("and_funct", {28'd0, out_funct}, 32'h7);
            end
            step();
        end

        // Backpressure for 5 cycles: head 0x48 held, requests stop.
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            #1;
            check_eq("bp_req", {31'd0, imem_req}, 32'd0);
            check_head("bp", 32'h48);
            step();
        end
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            check_head("rel", 32'(32'h48 + 4 * j));
            check_eq("rel_req", {31'd0, imem_req}, 32'd1);
            check_eq("rel_addr", imem_addr, 32'(32'h50 + 4 * j));
            step();
        end

        // Redirect while stalled with one response arriving (FIFO would fill).
        out_ready     = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        #1;
        check_eq("br1_req", {31'd0, imem_req}, 32'd0);
        step();
        branch_taken = 1'b0;
        out_ready    = 1'b1;
        #1;
        check_eq("br1_v1", {31'd0, out_valid}, 32'd0);
        check_eq("br1_req1", {31'd0, imem_req}, 32'd1);
        check_eq("br1_addr1", imem_addr, 32'h100);
        step();
        #1;
        check_eq("br1_v2", {31'd0, out_valid}, 32'd0);
        check_eq("br1_addr2", imem_addr, 32'h104);
        step();
        #1;
        check_head("br1_t3", 32'h100);
        step();
        #1;
        check_head("br1_t4", 32'h104);
        step();

        // Redirect with pop and push in the same cycle, then a second redirect.
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0200;
        #1;
        check_head("br2_pop", 32'h108);
        check_eq("br2_req", {31'd0, imem_req}, 32'd0);
        step();
        branch_target = 32'h0000_0302;
        #1;
        check_eq("br3_v0", {31'd0, out_valid}, 32'd0);
        check_eq("br3_req0", {31'd0, imem_req}, 32'd0);
        step();
        branch_taken = 1'b0;
        #1;
        check_eq("br3_v1", {31'd0, out_valid}, 32'd0);
        check_eq("br3_addr1", imem_addr, 32'h300);
        step();
        #1;
        check_eq("br3_v2", {31'd0, out_valid}, 32'd0);
        step();
        #1;
        check_head("br3_t3", 32'h300);
        step();
        #1;
        check_head("br3_t4", 32'h304);
        step();

        // Reset mid-stream, then restart at RESET_PC.
        rst_n = 1'b0;
        #1;
        check_eq("mrst_req", {31'd0, imem_req}, 32'd0);
        check_eq("mrst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mrst_pc", out_pc, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check_eq("mrst_v1", {31'd0, out_valid}, 32'd0);
        check_eq("mrst_req1", {31'd0, imem_req}, 32'd1);
        check_eq("mrst_addr1", imem_addr, 32'd0);
        step();
        #1;
        check_eq("mrst_v2", {31'd0, out_valid}, 32'd0);
        step();
        #1;
        check_head("mrst_t3", 32'h0);
        check_eq("mrst_word", out_instr, 32'hA5A5_0000);
        step();
        #1;
        check_head("mrst_t4", 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
